// File: rtl/dpcm_dec_if.sv
// dpcm_dec_if: handshake bundle between a DPCM difference source, the decoder and the DC sink.
// Input side: mode/diff_in/diff_valid from the source, diff_ready back to it.
// Output side: dc_out/dc_valid/dc_last/err_mode from the decoder, dc_ready from the sink.
// Port summary:
//   mode[1:0]    channel select, 01 Y / 10 Cr / 11 Cb / 00 invalid
//   diff_in[11:0] signed DPCM difference
//   diff_valid / diff_ready   input handshake
//   dc_out[11:0] signed reconstructed DC, dc_valid / dc_ready output handshake
//   dc_last      final DC of a channel run, qualified by dc_valid
//   err_mode     one-cycle pulse after an accepted mode 00 input
interface dpcm_dec_if;
    logic [1:0]  mode;
    logic [11:0] diff_in;
    logic        diff_valid;
    logic        diff_ready;
    logic [11:0] dc_out;
    logic        dc_valid;
    logic        dc_ready;
    logic        dc_last;
    logic        err_mode;

    // Source / sink side (testbench or upstream block).
    modport master (
        output mode,
        output diff_in,
        output diff_valid,
        output dc_ready,
        input  diff_ready,
        input  dc_out,
        input  dc_valid,
        input  dc_last,
        input  err_mode
    );

    // Decoder side.
    modport slave (
        input  mode,
        input  diff_in,
        input  diff_valid,
        input  dc_ready,
        output diff_ready,
        output dc_out,
        output dc_valid,
        output dc_last,
        output err_mode
    );
endinterface

// File: rtl/dpcm_dec.sv
// Purpose: DPCM DC decoder with independent Y/Cr/Cb channel runs (reference + run counter each).
// Latency: 1 cycle, accepted difference appears registered on dc_out the next cycle.
// Backpressure: diff_ready = !dc_valid || dc_ready, output held stable while stalled, full throughput.
// Ports: clk, rst (async, active-high), bus (dpcm_dec_if.slave, see interface header).
// Parameters: BLK_Y / BLK_CR / BLK_CB = DC values per channel run (1..512).
// Macro DPCM_CHAIN_EN: when defined, RUN output = ref + diff and the reference follows each output
//   (previous-block prediction); when undefined, RUN output = ref - diff with ref fixed to the
//   run's first DC.
module dpcm_dec #(
    parameter int BLK_Y  = 256,
    parameter int BLK_CR = 64,
    parameter int BLK_CB = 64
) (
    input  logic       clk,
    input  logic       rst,
    dpcm_dec_if.slave  bus
);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_RUN   = 1'b1
    } ch_state_t;

    localparam int NCH = 3;

    // Run lengths widened by one bit so that cnt + 1 never wraps before the compare.
    localparam logic [9:0] LEN_Y  = 10'(BLK_Y);
    localparam logic [9:0] LEN_CR = 10'(BLK_CR);
    localparam logic [9:0] LEN_CB = 10'(BLK_CB);

    // Per-channel state, index 0 = Y, 1 = Cr, 2 = Cb (mode code minus one).
    ch_state_t   state_q [NCH];
    logic [11:0] ref_q   [NCH];
    logic [8:0]  cnt_q   [NCH];

    logic        accept;
    logic        mode_ok;
    logic        sel_first;
    logic [11:0] sel_ref;
    logic [8:0]  sel_cnt;
    logic [9:0]  sel_len;
    logic [9:0]  cnt_inc;
    logic        last_next;
    logic [11:0] dc_next;
    logic [11:0] ref_next;

    // Output register is the only storage on the data path, so the input is free
    // whenever that register is empty or being drained this cycle.
    assign bus.diff_ready = !bus.dc_valid || bus.dc_ready;
    assign accept         = bus.diff_valid && bus.diff_ready;
    assign mode_ok        = (bus.mode != 2'b00);

    // Select the addressed channel's context. Mode 00 falls to harmless defaults;
    // nothing downstream uses them because an invalid mode never updates state or output.
    always_comb begin
        sel_first = 1'b1;
        sel_ref   = '0;
        sel_cnt   = '0;
        sel_len   = 10'd1;
        case (bus.mode)
            2'b01: begin
                sel_first = (state_q[0] == ST_FIRST);
                sel_ref   = ref_q[0];
                sel_cnt   = cnt_q[0];
                sel_len   = LEN_Y;
            end
            2'b10: begin
                sel_first = (state_q[1] == ST_FIRST);
                sel_ref   = ref_q[1];
                sel_cnt   = cnt_q[1];
                sel_len   = LEN_CR;
            end
            2'b11: begin
                sel_first = (state_q[2] == ST_FIRST);
                sel_ref   = ref_q[2];
                sel_cnt   = cnt_q[2];
                sel_len   = LEN_CB;
            end
            default: begin
                sel_first = 1'b1;
            end
        endcase
    end

    // Reconstruction. cnt is 0 while a channel sits in FIRST, so cnt + 1 == 1 there and
    // the same compare covers the first value of a run (a run length of 1 ends immediately).
    always_comb begin
        cnt_inc   = {1'b0, sel_cnt} + 10'd1;
        last_next = (cnt_inc == sel_len);
        dc_next   = bus.diff_in;
        ref_next  = bus.diff_in;
        if (!sel_first) begin
`ifdef DPCM_CHAIN_EN
            dc_next  = sel_ref + bus.diff_in;
            ref_next = dc_next;
`else
            dc_next  = sel_ref - bus.diff_in;
            ref_next = sel_ref;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_FIRST;
                ref_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            bus.dc_out   <= '0;
            bus.dc_valid <= 1'b0;
            bus.dc_last  <= 1'b0;
            bus.err_mode <= 1'b0;
        end else begin
            bus.err_mode <= accept && !mode_ok;

            if (accept && mode_ok) begin
                bus.dc_out   <= dc_next;
                bus.dc_valid <= 1'b1;
                bus.dc_last  <= last_next;
            end else if (bus.dc_ready) begin
                // dc_out keeps its last value; only the qualifiers drop.
                bus.dc_valid <= 1'b0;
                bus.dc_last  <= 1'b0;
            end

            for (int i = 0; i < NCH; i++) begin
                if (accept && (bus.mode == 2'(i + 1))) begin
                    if (last_next) begin
                        state_q[i] <= ST_FIRST;
                        ref_q[i]   <= '0;
                        cnt_q[i]   <= '0;
                    end else begin
                        state_q[i] <= ST_RUN;
                        ref_q[i]   <= ref_next;
                        cnt_q[i]   <= cnt_inc[8:0];
                    end
                end
            end
        end
    end

    // Protocol properties of the output side.
    a_last_needs_valid: assert property (@(posedge clk) disable iff (rst)
        bus.dc_last |-> bus.dc_valid);

    a_hold_when_stalled: assert property (@(posedge clk) disable iff (rst)
        (bus.dc_valid && !bus.dc_ready) |=>
            (bus.dc_valid && $stable(bus.dc_out) && $stable(bus.dc_last)));

endmodule

// File: tb/tb_dpcm_dec.sv
// Testbench for dpcm_dec: directed scenarios plus randomized traffic against a reference model.
// Cr is built with a run length of 1 so that single-value runs are exercised alongside 64 and 256.
module tb_dpcm_dec;

    localparam int BLK_Y  = 256;
    localparam int BLK_CR = 1;
    localparam int BLK_CB = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dpcm_dec_if bus ();

    dpcm_dec #(
        .BLK_Y  (BLK_Y),
        .BLK_CR (BLK_CR),
        .BLK_CB (BLK_CB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: position within the current run and the prediction base per channel.
    int pos  [3];
    int base [3];
    int blk  [3];

    function automatic void model_clear();
        blk[0] = BLK_Y;
        blk[1] = BLK_CR;
        blk[2] = BLK_CB;
        for (int c = 0; c < 3; c++) begin
            pos[c]  = 0;
            base[c] = 0;
        end
    endfunction

    function automatic void model_accept(input logic [1:0] m, input logic [11:0] d,
                                         output logic [11:0] v, output logic l);
        int c;
        int dv;
        int r;
        c  = int'(m) - 1;
        dv = int'($signed(d));
        if (pos[c] == 0) begin
            r       = dv;
            base[c] = dv;
        end else begin
`ifdef DPCM_CHAIN_EN
            r       = base[c] + dv;
            base[c] = int'($signed(12'(r)));
`else
            r       = base[c] - dv;
`endif
        end
        v      = 12'(r);
        pos[c] = pos[c] + 1;
        l      = (pos[c] == blk[c]);
        if (l) begin
            pos[c]  = 0;
            base[c] = 0;
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.diff_valid = 1'b0;
        bus.mode       = 2'b00;
        bus.diff_in    = '0;
        bus.dc_ready   = 1'b1;
        rst = 1'b1;
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        model_clear();
    endtask

    // Presents one input for one cycle (sink assumed ready) and updates the model.
    task automatic send(input logic [1:0] m, input logic [11:0] d,
                        output logic [11:0] v, output logic l);
        bus.diff_valid = 1'b1;
        bus.mode       = m;
        bus.diff_in    = d;
        v = '0;
        l = 1'b0;
        if (m != 2'b00) model_accept(m, d, v, l);
        cyc();
    endtask

    task automatic idle();
        bus.diff_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        bus.diff_valid = 1'b0;
        bus.mode       = 2'b00;
        bus.diff_in    = '0;
        bus.dc_ready   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.dc_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.dc_valid); else passes++;
        checks++; if (bus.dc_last !== 1'b0) $display("FAIL reset_last: got %b want 0", bus.dc_last); else passes++;
        checks++; if (bus.dc_out !== 12'd0) $display("FAIL reset_out: got %h want 000", bus.dc_out); else passes++;
        checks++; if (bus.err_mode !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_mode); else passes++;
        checks++; if (bus.diff_ready !== 1'b1) $display("FAIL reset_ready_during: got %b want 1", bus.diff_ready); else passes++;
        cyc();
        cyc();
        rst = 1'b0;
        model_clear();
        cyc();
        checks++; if (bus.diff_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", bus.diff_ready); else passes++;
    endtask

    task automatic test_basic();
        logic [11:0] v;
        logic        l;
        logic [11:0] e2;
        logic [11:0] e3;
`ifdef DPCM_CHAIN_EN
        e2 = 12'd130;
        e3 = 12'd125;
`else
        e2 = 12'd70;
        e3 = 12'd105;
`endif
        do_reset();
        send(2'b11, 12'd100, v, l);
        checks++; if (bus.dc_valid !== 1'b1) $display("FAIL basic_lat1_valid: got %b want 1", bus.dc_valid); else passes++;
        checks++; if (bus.dc_out !== 12'd100) $display("FAIL basic_dc1: got %0d want 100", bus.dc_out); else passes++;
        send(2'b11, 12'd30, v, l);
        checks++; if (bus.dc_out !== e2) $display("FAIL basic_dc2: got %0d want %0d", bus.dc_out, e2); else passes++;
        send(2'b11, 12'hFFB, v, l);
        checks++; if (bus.dc_out !== e3) $display("FAIL basic_dc3: got %0d want %0d", bus.dc_out, e3); else passes++;
        checks++; if (bus.dc_last !== 1'b0) $display("FAIL basic_last: got %b want 0", bus.dc_last); else passes++;
        idle();
        checks++; if (bus.dc_valid !== 1'b0) $display("FAIL basic_valid_clear: got %b want 0", bus.dc_valid); else passes++;
        checks++; if (bus.dc_last !== 1'b0) $display("FAIL basic_last_clear: got %b want 0", bus.dc_last); else passes++;
    endtask

    task automatic test_blk_one();
        logic [11:0] v;
        logic        l;
        do_reset();
        send(2'b10, 12'd5, v, l);
        checks++; if (bus.dc_out !== 12'd5) $display("FAIL blk1_dc_a: got %0d want 5", bus.dc_out); else passes++;
        checks++; if (bus.dc_last !== 1'b1) $display("FAIL blk1_last_a: got %b want 1", bus.dc_last); else passes++;
        send(2'b10, 12'd9, v, l);
        checks++; if (bus.dc_out !== 12'd9) $display("FAIL blk1_dc_b: got %0d want 9", bus.dc_out); else passes++;
        checks++; if (bus.dc_last !== 1'b1) $display("FAIL blk1_last_b: got %b want 1", bus.dc_last); else passes++;
        idle();
    endtask

    task automatic test_run_length();
        logic [11:0] v;
        logic        l;
        do_reset();
        for (int i = 1; i <= 64; i++) begin
            send(2'b11, 12'($urandom), v, l);
            checks++; if (bus.dc_out !== v) $display("FAIL run_dc[%0d]: got %h want %h", i, bus.dc_out, v); else passes++;
            checks++; if (bus.dc_last !== (i == 64)) $display("FAIL run_last[%0d]: got %b want %b", i, bus.dc_last, (i == 64)); else passes++;
        end
        send(2'b11, 12'd7, v, l);
        checks++; if (bus.dc_out !== 12'd7) $display("FAIL run_65th_first: got %0d want 7", bus.dc_out); else passes++;
        checks++; if (bus.dc_last !== 1'b0) $display("FAIL run_65th_last: got %b want 0", bus.dc_last); else passes++;
        idle();
    endtask

    task automatic test_back_to_back();
        logic [11:0] v;
        logic        l;
        logic [11:0] pend;
        do_reset();
        send(2'b11, 12'd100, v, l);
        send(2'b11, 12'd30, pend, l);
        bus.dc_ready   = 1'b0;
        bus.mode       = 2'b11;
        bus.diff_in    = 12'hFFB;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.diff_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", k, bus.diff_ready); else passes++;
            checks++; if (bus.dc_out !== pend || bus.dc_valid !== 1'b1)
                $display("FAIL bp_hold[%0d]: got %0d/%b want %0d/1", k, bus.dc_out, bus.dc_valid, pend); else passes++;
            cyc();
        end
        bus.dc_ready = 1'b1;
        #1;
        checks++; if (bus.diff_ready !== 1'b1) $display("FAIL bp_ready_resume: got %b want 1", bus.diff_ready); else passes++;
        model_accept(2'b11, 12'hFFB, v, l);
        cyc();
        checks++; if (bus.dc_out !== v) $display("FAIL bp_not_lost: got %0d want %0d", bus.dc_out, v); else passes++;
        for (int k = 0; k < 4; k++) begin
            send(2'b11, 12'($urandom_range(0, 4095)), v, l);
            checks++; if (bus.dc_valid !== 1'b1 || bus.dc_out !== v)
                $display("FAIL b2b[%0d]: got %h/%b want %h/1", k, bus.dc_out, bus.dc_valid, v); else passes++;
        end
        idle();
    endtask

    task automatic test_interleave();
        logic [11:0] v;
        logic        l;
        logic [11:0] ey;
        logic [11:0] ecb;
`ifdef DPCM_CHAIN_EN
        ey  = 12'd13;
        ecb = 12'd25;
`else
        ey  = 12'd7;
        ecb = 12'd15;
`endif
        do_reset();
        send(2'b01, 12'd10, v, l);
        checks++; if (bus.dc_out !== 12'd10) $display("FAIL il_y_first: got %0d want 10", bus.dc_out); else passes++;
        send(2'b11, 12'd20, v, l);
        checks++; if (bus.dc_out !== 12'd20) $display("FAIL il_cb_first: got %0d want 20", bus.dc_out); else passes++;
        send(2'b01, 12'd3, v, l);
        checks++; if (bus.dc_out !== ey) $display("FAIL il_y_run: got %0d want %0d", bus.dc_out, ey); else passes++;
        send(2'b11, 12'd5, v, l);
        checks++; if (bus.dc_out !== ecb) $display("FAIL il_cb_run: got %0d want %0d", bus.dc_out, ecb); else passes++;
        idle();
    endtask

    task automatic test_wrap_err_reset();
        logic [11:0] v;
        logic        l;
        logic [11:0] ew;
`ifdef DPCM_CHAIN_EN
        ew = 12'h7FE;
`else
        ew = 12'h800;
`endif
        do_reset();
        send(2'b01, 12'd2047, v, l);
        send(2'b01, 12'hFFF, v, l);
        checks++; if (bus.dc_out !== ew) $display("FAIL wrap: got %h want %h", bus.dc_out, ew); else passes++;
        send(2'b00, 12'd123, v, l);
        checks++; if (bus.err_mode !== 1'b1) $display("FAIL err_pulse: got %b want 1", bus.err_mode); else passes++;
        checks++; if (bus.dc_valid !== 1'b0) $display("FAIL err_no_valid: got %b want 0", bus.dc_valid); else passes++;
        idle();
        checks++; if (bus.err_mode !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", bus.err_mode); else passes++;
        send(2'b01, 12'd40, v, l);
        checks++; if (bus.dc_out !== v) $display("FAIL err_no_state_change: got %h want %h", bus.dc_out, v); else passes++;
        bus.dc_ready = 1'b0;
        bus.diff_in  = 12'd50;
        cyc();
        rst = 1'b1;
        #1;
        checks++; if (bus.dc_valid !== 1'b0 || bus.dc_last !== 1'b0 || bus.dc_out !== 12'd0)
            $display("FAIL rst_mid_run: got %h/%b/%b want 000/0/0", bus.dc_out, bus.dc_valid, bus.dc_last); else passes++;
        cyc();
        rst = 1'b0;
        model_clear();
        bus.dc_ready = 1'b1;
        send(2'b01, 12'd55, v, l);
        checks++; if (bus.dc_out !== 12'd55) $display("FAIL rst_then_first: got %0d want 55", bus.dc_out); else passes++;
        idle();
    endtask

    typedef struct {
        logic [11:0] v;
        logic        l;
    } exp_t;

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic        exp_err;
        logic        exp_rdy;
        logic        acc;
        do_reset();
        exp_err = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bus.diff_valid = ($urandom_range(0, 3) != 0);
            bus.mode       = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            bus.diff_in    = 12'($urandom);
            bus.dc_ready   = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q.size() == 0) || bus.dc_ready;
            checks++; if (bus.err_mode !== exp_err) $display("FAIL rnd_err[%0d]: got %b want %b", n, bus.err_mode, exp_err); else passes++;
            checks++; if (bus.dc_valid !== (q.size() != 0)) $display("FAIL rnd_valid[%0d]: got %b want %b", n, bus.dc_valid, (q.size() != 0)); else passes++;
            checks++; if (bus.diff_ready !== exp_rdy) $display("FAIL rnd_ready[%0d]: got %b want %b", n, bus.diff_ready, exp_rdy); else passes++;
            if (q.size() != 0) begin
                checks++; if (bus.dc_out !== q[0].v || bus.dc_last !== q[0].l)
                    $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b", n, bus.dc_out, bus.dc_last, q[0].v, q[0].l); else passes++;
                if (bus.dc_ready) void'(q.pop_front());
            end else begin
                checks++; if (bus.dc_last !== 1'b0) $display("FAIL rnd_last_idle[%0d]: got %b want 0", n, bus.dc_last); else passes++;
            end
            acc     = bus.diff_valid && exp_rdy;
            exp_err = acc && (bus.mode == 2'b00);
            if (acc && bus.mode != 2'b00) begin
                model_accept(bus.mode, bus.diff_in, e.v, e.l);
                q.push_back(e);
            end
            cyc();
        end
        bus.diff_valid = 1'b0;
        bus.dc_ready   = 1'b1;
        cyc();
    endtask

    initial begin
        bus.diff_valid = 1'b0;
        bus.mode       = 2'b00;
        bus.diff_in    = '0;
        bus.dc_ready   = 1'b1;
        test_reset();
        test_basic();
        test_blk_one();
        test_run_length();
        test_back_to_back();
        test_interleave();
        test_wrap_err_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/dpcm_dec.md
DPCM_DEC -- requirements
Module: dpcm_dec

Interface
REQ-001 SHALL have parameter BLK_Y, 256, DC values per Y frame run.
REQ-002 SHALL have parameter BLK_CR, 64, DC values per Cr frame run.
REQ-003 SHALL have parameter BLK_CB, 64, DC values per Cb frame run.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port mode  input  2  channel select (01 Y, 10 Cr, 11 Cb, 00 invalid), sampled with diff_valid.
REQ-007 SHALL have port diff_in  input  12  signed DPCM difference.
REQ-008 SHALL have port diff_valid  input  1  diff_in/mode valid.
REQ-009 SHALL have port diff_ready  output  1  decoder accepts input this cycle.
REQ-010 SHALL have port dc_out  output  12  signed reconstructed DC value.
REQ-011 SHALL have port dc_valid  output  1  dc_out valid.
REQ-012 SHALL have port dc_ready  input  1  downstream accepts dc_out.
REQ-013 SHALL have port dc_last  output  1  dc_out is final DC of its channel run, qualified by dc_valid.
REQ-014 SHALL have port err_mode  output  1  one-cycle pulse: input accepted with mode 00.

Function
REQ-015 Accept = diff_valid && diff_ready; diff_ready SHALL equal !dc_valid || dc_ready (full throughput, no bubble).
REQ-016 Output SHALL be registered: accepted input appears on dc_out/dc_valid the following cycle (latency 1).
REQ-017 While dc_valid && !dc_ready, dc_out, dc_last, dc_valid SHALL hold stable.
REQ-018 dc_valid SHALL clear after a dc_ready handshake unless a new input is accepted that same cycle.
REQ-019 Each channel SHALL keep an independent state (FIRST/RUN), 12-bit reference register ref_c and 9-bit counter cnt_c.
REQ-020 FIRST, accept: dc = diff_in; ref_c <= diff_in; cnt_c <= 1; -> RUN.
REQ-021 RUN, accept: dc = ref_c - diff_in (default build); cnt_c <= cnt_c + 1.
REQ-022 Arithmetic SHALL be 12-bit two's complement, wrap on overflow, no saturation.
REQ-023 When cnt_c + 1 equals the channel's BLK parameter (FIRST counts as 1), dc_last SHALL be 1 with that output; channel -> FIRST, cnt_c <= 0, ref_c <= 0.
REQ-024 BLK parameter of 1 SHALL make every value both first and last.
REQ-025 Accepting one channel SHALL NOT alter state/ref/cnt of the others; mode may change every transaction.
REQ-026 mode 00 accepted: input discarded, no dc_valid, err_mode = 1 the next cycle, no channel state change.
REQ-027 dc_last SHALL be 0 whenever dc_valid is 0.

Reset
REQ-028 rst SHALL asynchronously force: all channels FIRST, all ref_c = 0, all cnt_c = 0, dc_out = 0, dc_valid = 0, dc_last = 0, err_mode = 0.
REQ-029 diff_ready SHALL be 1 while and after reset (output empty).
REQ-030 Reset mid-run SHALL discard any pending output; the next accepted value per channel is a first value.

Configuration
REQ-031 Macro DPCM_CHAIN_EN SHALL select the prediction mode.
REQ-032 Without DPCM_CHAIN_EN: reference fixed to the run's first DC; RUN output = ref_c - diff_in; ref_c unchanged in RUN.
REQ-033 With DPCM_CHAIN_EN: RUN output = ref_c + diff_in; ref_c <= that output each accept (previous-block prediction); FIRST unchanged.

Verification
REQ-034 Default build, Cb: diffs 100, 30, 0xFFB(-5) -> dc_out 100, 70, 105, each 1 cycle after accept.
REQ-035 DPCM_CHAIN_EN, Cb: diffs 100, 30, 0xFFB -> dc_out 100, 130, 125.
REQ-036 64 consecutive Cb inputs -> dc_last=1 on 64th output only; 65th input (diff 7) -> dc_out 7, treated as first.
REQ-037 dc_ready low 3 cycles with dc_out=70 pending -> dc_out stable, diff_ready=0, no input lost; then resume at 1 transaction/cycle.
REQ-038 Interleave Y first 10, Cb first 20, Y diff 3 (default) -> dc_out 10, 20, 7; Cb cnt unaffected by Y.
REQ-039 Default, Y first 2047 then diff 0xFFF(-1) -> dc_out 0x800 (wrap); mode 00 input -> err_mode pulse, no dc_valid; rst mid-run -> next Y input is first.
